// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding and counter-width helpers for the systolic sequencer
package systolic_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FEED    = 3'd2,
        S_DRAIN   = 3'd3,
        S_READOUT = 3'd4,
        S_DONE    = 3'd5
    } seq_state_t;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int cnt_w(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/start_skew.sv
// rtl/start_skew.sv - diagonal start-enable skew: bit 0 combinational, bit i is bit i-1 one clock late
module start_skew #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         first,
    output logic [W-1:0] en
);

    logic [W-1:1] dly;

    assign en = {dly, first};

    // Shift every cycle, so the wavefront keeps travelling and zeros follow it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly <= '0;
        end else begin
            dly <= en[W-2:0];
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - counted clear/feed/drain/readout schedule for one systolic matmul pass
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int K_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [K_W-1:0]       k_len,
    output logic                 busy,
    output logic                 done,
    output logic                 mac_clear,
    output logic                 load,
    output logic                 a_rd_en,
    output logic                 b_rd_en,
    output logic [K_W-1:0]       a_rd_addr,
    output logic [K_W-1:0]       b_rd_addr,
    output logic [N-1:0]         a_start_en,
    output logic [M-1:0]         b_start_en,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_row,
    input  logic                 out_ready
);

    localparam int DW = cnt_w(N + M);
    localparam int RW = $clog2(N);

    localparam logic [DW-1:0] DRAIN_LAST = DW'(N + M - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N - 1);

    seq_state_t     state;
    seq_state_t     state_next;
    logic [K_W-1:0] k_len_q;
    logic [K_W-1:0] k_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [RW-1:0]  row_cnt;
    logic           feeding;
    logic           stay;

    assign feeding = (state == S_FEED);
    assign stay    = (state_next == state);

    // State register; reset abandons any pass in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counters restart from zero on every state entry and only advance while the state holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len_q   <= '0;
            k_cnt     <= '0;
            drain_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            if (state == S_IDLE && start && k_len != '0) begin
                k_len_q <= k_len;
            end
            k_cnt     <= (feeding && stay) ? k_cnt + K_W'(1) : '0;
            drain_cnt <= (state == S_DRAIN && stay) ? drain_cnt + DW'(1) : '0;
            if (state == S_READOUT && stay) begin
                if (out_ready) begin
                    row_cnt <= row_cnt + RW'(1);
                end
            end else begin
                row_cnt <= '0;
            end
        end
    end

    // Next-state decode and per-state strobes; everything is idle unless a state claims it.
    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        mac_clear  = 1'b0;
        load       = 1'b0;
        a_rd_en    = 1'b0;
        b_rd_en    = 1'b0;
        a_rd_addr  = '0;
        b_rd_addr  = '0;
        out_valid  = 1'b0;
        out_row    = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (k_len == '0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clear  = 1'b1;
                state_next = S_FEED;
            end
            S_FEED: begin
                load      = 1'b1;
                a_rd_en   = 1'b1;
                b_rd_en   = 1'b1;
                a_rd_addr = k_cnt;
                b_rd_addr = k_cnt;
                if (k_cnt == k_len_q - K_W'(1)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                load = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = S_READOUT;
                end
            end
            S_READOUT: begin
                out_valid = 1'b1;
                out_row   = row_cnt;
                if (out_ready && row_cnt == ROW_LAST) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Row enables: wavefront enters row 0 with the FEED address.
    start_skew #(.W(N)) u_a_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .first (feeding),
        .en    (a_start_en)
    );

    // Column enables: same wavefront along the B lanes.
    start_skew #(.W(M)) u_b_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .first (feeding),
        .en    (b_start_en)
    );

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed self-checking bench for systolic_sequencer
module tb_systolic_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start = 1'b0;
    logic [7:0] k_len = '0;
    logic       out_ready = 1'b1;
    logic       busy, done, mac_clear, load, a_rd_en, b_rd_en, out_valid;
    logic [7:0] a_rd_addr, b_rd_addr;
    logic [1:0] a_start_en, b_start_en;
    logic [0:0] out_row;

    logic       start2 = 1'b0;
    logic [7:0] k_len2 = '0;
    logic       out_ready2 = 1'b1;
    logic       busy2, done2, mac_clear2, load2, a_rd_en2, b_rd_en2, out_valid2;
    logic [7:0] a_rd_addr2, b_rd_addr2;
    logic [3:0] a_start_en2;
    logic [1:0] b_start_en2;
    logic [1:0] out_row2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] obs;
    assign obs = {busy, done, mac_clear, load, a_rd_en, b_rd_en, out_valid, out_row,
                  a_rd_addr[3:0], a_start_en, b_start_en};

    always #5 clk = ~clk;

    systolic_sequencer #(.N(2), .M(2), .K_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .mac_clear(mac_clear), .load(load),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_start_en(a_start_en), .b_start_en(b_start_en),
        .out_valid(out_valid), .out_row(out_row), .out_ready(out_ready)
    );

    systolic_sequencer #(.N(4), .M(2), .K_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .k_len(k_len2),
        .busy(busy2), .done(done2), .mac_clear(mac_clear2), .load(load2),
        .a_rd_en(a_rd_en2), .b_rd_en(b_rd_en2), .a_rd_addr(a_rd_addr2), .b_rd_addr(b_rd_addr2),
        .a_start_en(a_start_en2), .b_start_en(b_start_en2),
        .out_valid(out_valid2), .out_row(out_row2), .out_ready(out_ready2)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs !== 16'h0 || b_rd_addr !== 8'h0 || a_rd_addr !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_dut: got obs=%b b_addr=%0d want all zero", obs, b_rd_addr);
        end
        n_cmp++;
        if ({busy2, done2, mac_clear2, load2, a_rd_en2, b_rd_en2, out_valid2, out_row2,
             a_start_en2, b_start_en2} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset_dut2: got busy=%b load=%b a_en=%b want all zero",
                     busy2, load2, a_start_en2);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_main_pass();
        logic [15:0] exp_tab [1:11];
        // {busy,done,clr,load,ard,brd,ov,row}_{addr[3:0]}_{a_en}_{b_en}
        exp_tab[1]  = 16'b1010_0000_0000_00_00;
        exp_tab[2]  = 16'b1001_1100_0000_01_01;
        exp_tab[3]  = 16'b1001_1100_0001_11_11;
        exp_tab[4]  = 16'b1001_1100_0010_11_11;
        exp_tab[5]  = 16'b1001_0000_0000_10_10;
        exp_tab[6]  = 16'b1001_0000_0000_00_00;
        exp_tab[7]  = 16'b1001_0000_0000_00_00;
        exp_tab[8]  = 16'b1000_0010_0000_00_00;
        exp_tab[9]  = 16'b1000_0011_0000_00_00;
        exp_tab[10] = 16'b1100_0000_0000_00_00;
        exp_tab[11] = 16'b0000_0000_0000_00_00;
        @(negedge clk);
        out_ready = 1'b1;
        k_len = 8'd3;
        start = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (obs !== exp_tab[c]) begin
                n_bad++;
                $display("FAIL main_pass cycle %0d: got %b want %b", c, obs, exp_tab[c]);
            end
            if (c == 4) begin
                n_cmp++;
                if (b_rd_addr !== 8'd2) begin
                    n_bad++;
                    $display("FAIL main_b_addr: got %0d want 2", b_rd_addr);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int viol = 0;
        @(negedge clk);
        k_len = 8'd0;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mac_clear || load || a_rd_en || b_rd_en) viol++;
            if (c == 1) begin
                n_cmp++;
                if ({busy, done} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL zero_len_done: got busy/done=%b want 11", {busy, done});
                end
            end
            if (c == 2) begin
                n_cmp++;
                if ({busy, done} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL zero_len_idle: got busy/done=%b want 00", {busy, done});
                end
            end
        end
        n_cmp++;
        if (viol !== 0) begin
            n_bad++;
            $display("FAIL zero_len_strobes: got %0d strobe cycles want 0", viol);
        end
    endtask

    task automatic test_backpressure();
        int done_cyc = 0;
        int stall_bad = 0;
        @(negedge clk);
        k_len = 8'd1;
        start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && done_cyc == 0) done_cyc = c;
            if (c >= 6 && c <= 10 && (out_valid !== 1'b1 || out_row !== 1'b0)) stall_bad++;
            out_ready = (c >= 6 && c <= 10) ? 1'b0 : 1'b1;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (stall_bad !== 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: got %0d bad stall cycles want 0", stall_bad);
        end
        n_cmp++;
        if (done_cyc !== 13) begin
            n_bad++;
            $display("FAIL backpressure_done: got cycle %0d want 13", done_cyc);
        end
    endtask

    task automatic test_ignored_start();
        int feed = 0;
        int clr = 0;
        int done_cyc = 0;
        @(negedge clk);
        k_len = 8'd3;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (a_rd_en) feed++;
            if (mac_clear) clr++;
            if (done && done_cyc == 0) done_cyc = c;
            start = (c == 3 || c == 8) ? 1'b1 : 1'b0;
            if (c == 3) k_len = 8'd7;
        end
        n_cmp++;
        if (feed !== 3) begin
            n_bad++;
            $display("FAIL ignored_feed_len: got %0d want 3", feed);
        end
        n_cmp++;
        if (clr !== 1) begin
            n_bad++;
            $display("FAIL ignored_clear_count: got %0d want 1", clr);
        end
        n_cmp++;
        if (done_cyc !== 10) begin
            n_bad++;
            $display("FAIL ignored_done: got cycle %0d want 10", done_cyc);
        end
    endtask

    task automatic test_reset_mid_pass();
        int done_seen = 0;
        int done_cyc = 0;
        @(negedge clk);
        k_len = 8'd3;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++;
        if ({load, a_rd_en} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_pre_drain: got load/rd=%b want 10", {load, a_rd_en});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 16'h0 || b_rd_addr !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_async: got obs=%b want all zero", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++;
            $display("FAIL reset_no_done: got %0d done pulses want 0", done_seen);
        end
        k_len = 8'd1;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && done_cyc == 0) done_cyc = c;
        end
        n_cmp++;
        if (done_cyc !== 8) begin
            n_bad++;
            $display("FAIL reset_recover_done: got cycle %0d want 8", done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        int done_cyc = 0;
        int clr_cyc = 0;
        @(negedge clk);
        k_len = 8'd1;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done && c > 1) begin
                if (done_cyc == 0) done_cyc = c;
            end
            if (mac_clear && c > 1 && clr_cyc == 0) clr_cyc = c;
            if (c == 9) begin
                n_cmp++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
                end
            end
            if (c == 10) start = 1'b0;
        end
        n_cmp++;
        if (done_cyc !== 8) begin
            n_bad++;
            $display("FAIL b2b_first_done: got cycle %0d want 8", done_cyc);
        end
        n_cmp++;
        if (clr_cyc !== 10) begin
            n_bad++;
            $display("FAIL b2b_second_clear: got cycle %0d want 10", clr_cyc);
        end
    endtask

    task automatic test_wide_array();
        int b0 = 0;
        int b1 = 0;
        int a3 = 0;
        int drain = 0;
        int done_cyc = 0;
        @(negedge clk);
        k_len2 = 8'd5;
        start2 = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (b_start_en2[0] && b0 == 0) b0 = c;
            if (b_start_en2[1] && b1 == 0) b1 = c;
            if (a_start_en2[3] && a3 == 0) a3 = c;
            if (load2 && !a_rd_en2) drain++;
            if (done2 && done_cyc == 0) done_cyc = c;
        end
        n_cmp++;
        if (b0 !== 2 || b1 !== 3) begin
            n_bad++;
            $display("FAIL wide_b_skew: got b0=%0d b1=%0d want 2 3", b0, b1);
        end
        n_cmp++;
        if (a3 !== 5) begin
            n_bad++;
            $display("FAIL wide_a3_skew: got %0d want 5", a3);
        end
        n_cmp++;
        if (drain !== 5) begin
            n_bad++;
            $display("FAIL wide_drain_len: got %0d want 5", drain);
        end
        n_cmp++;
        if (done_cyc !== 16) begin
            n_bad++;
            $display("FAIL wide_done: got cycle %0d want 16", done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_main_pass();
        test_zero_len();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_pass();
        test_back_to_back();
        test_wide_array();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
